// File: rtl/idli_sqi_ctrl_m.sv
// idli_sqi_ctrl_m: single-request SQI master. Sends opcode and address, then
// optional dummy slots, then reads or writes one data word, one nibble per SCK slot.
package idli_sqi_pkg;
  typedef enum logic {
    SQI_MODE_IN  = 1'b0,
    SQI_MODE_OUT = 1'b1
  } sqi_mode_t;
endpackage

module idli_sqi_ctrl_m
  import idli_sqi_pkg::*;
#(
  parameter int         ADDR_W       = 16,
  parameter int         DATA_NIBBLES = 4,
  parameter int         NUM_CS       = 2,
  parameter int         DUMMY_CYC    = 2,
  parameter logic [7:0] RD_OP        = 8'h03,
  parameter logic [7:0] WR_OP        = 8'h02,
  localparam int        DATA_W       = 4 * DATA_NIBBLES,
  localparam int        CS_W         = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              i_sqi_gck,
  input  logic              i_sqi_rst,
  input  logic              i_sqi_req_vld,
  output logic              o_sqi_req_acp,
  input  logic              i_sqi_req_wr,
  input  logic [CS_W-1:0]   i_sqi_req_cs,
  input  logic [ADDR_W-1:0] i_sqi_req_addr,
  input  logic [DATA_W-1:0] i_sqi_req_wdata,
  output logic              o_sqi_rsp_vld,
  input  logic              i_sqi_rsp_acp,
  output logic [DATA_W-1:0] o_sqi_rsp_rdata,
  output logic              o_sqi_rsp_err,
  output logic              o_sqi_sck,
  output logic [NUM_CS-1:0] o_sqi_cs,
  output sqi_mode_t         o_sqi_mode,
  input  logic [3:0]        i_sqi_data,
  output logic [3:0]        o_sqi_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_END   = 3'd5;
  localparam logic [2:0] S_RSP   = 3'd6;

  localparam logic [3:0] ADDR_LAST  = 4'(ADDR_W / 4 - 1);
  localparam logic [3:0] DUMMY_LAST = 4'((DUMMY_CYC > 0) ? DUMMY_CYC - 1 : 0);
  localparam logic [3:0] DATA_LAST  = 4'(DATA_NIBBLES - 1);

  logic [2:0]        state_q, state_d;
  logic              phase_q, phase_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              acp_q, acp_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [CS_W-1:0]   cs_q, cs_d;
  logic [7:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              active;

  assign active = (state_q == S_CMD) || (state_q == S_ADDR) ||
                  (state_q == S_DUMMY) || (state_q == S_DATA);

  // phase_q=0 is the SCK-low half of a slot, phase_q=1 the SCK-high half;
  // every shift and state change happens at the edge ending the high half.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    err_d   = err_q;
    cs_d    = cs_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    if (active) begin
      phase_d = ~phase_q;
      if (phase_q) cnt_d = cnt_q + 4'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_sqi_req_vld && acp_q) begin
          wr_d    = i_sqi_req_wr;
          cs_d    = i_sqi_req_cs;
          addr_d  = i_sqi_req_addr;
          wdata_d = i_sqi_req_wdata;
          op_d    = i_sqi_req_wr ? WR_OP : RD_OP;
          rdata_d = '0;
          phase_d = 1'b0;
          cnt_d   = '0;
          if (32'(i_sqi_req_cs) >= 32'(NUM_CS)) begin
            err_d   = 1'b1;
            state_d = S_RSP;
          end else begin
            err_d   = 1'b0;
            state_d = S_CMD;
          end
        end
      end
      S_CMD: begin
        if (phase_q) begin
          op_d = op_q << 4;
          if (cnt_q == 4'd1) begin
            cnt_d   = '0;
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (phase_q) begin
          addr_d = addr_q << 4;
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            state_d = (wr_q || DUMMY_CYC == 0) ? S_DATA : S_DUMMY;
          end
        end
      end
      S_DUMMY: begin
        if (phase_q && cnt_q == DUMMY_LAST) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (phase_q) begin
          wdata_d = wdata_q << 4;
          if (!wr_q) rdata_d = (rdata_q << 4) | DATA_W'(i_sqi_data);
          if (cnt_q == DATA_LAST) begin
            cnt_d   = '0;
            state_d = S_END;
          end
        end
      end
      S_END:   state_d = S_RSP;
      S_RSP:   if (i_sqi_rsp_acp) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Held low through reset so the first acceptance comes one edge after release.
    acp_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      cnt_q   <= '0;
      acp_q   <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      acp_q   <= acp_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_sqi_req_acp   = acp_q;
  assign o_sqi_rsp_vld   = (state_q == S_RSP);
  assign o_sqi_rsp_err   = err_q && o_sqi_rsp_vld;
  assign o_sqi_rsp_rdata = o_sqi_rsp_vld ? rdata_q : '0;
  assign o_sqi_sck       = active && phase_q;

  always_comb begin
    o_sqi_cs   = '1;
    o_sqi_mode = SQI_MODE_IN;
    o_sqi_data = 4'h0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (active && cs_q == CS_W'(i)) o_sqi_cs[i] = 1'b0;
    end
    case (state_q)
      S_CMD: begin
        o_sqi_mode = SQI_MODE_OUT;
        o_sqi_data = op_q[7:4];
      end
      S_ADDR: begin
        o_sqi_mode = SQI_MODE_OUT;
        o_sqi_data = addr_q[ADDR_W-1 -: 4];
      end
      S_DATA: begin
        if (wr_q) begin
          o_sqi_mode = SQI_MODE_OUT;
          o_sqi_data = wdata_q[DATA_W-1 -: 4];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Randomized bench for idli_sqi_ctrl_m: two configurations driven from shared
// stimulus, every transfer compared against a slot-level model of the protocol.
module tb_idli_sqi_ctrl_m;
  import idli_sqi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Shared stimulus; sel picks which DUT gets vld and which outputs are observed.
  logic        sel = 1'b0;
  logic        vld = 1'b0, wr = 1'b0, rsp_acp = 1'b0;
  logic [1:0]  cs = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  sio_in = '0;

  logic        a_acp, a_rsp_vld, a_err, a_sck;
  logic [15:0] a_rdata;
  logic [2:0]  a_cs;
  sqi_mode_t   a_mode;
  logic [3:0]  a_data;

  logic        b_acp, b_rsp_vld, b_err, b_sck;
  logic [7:0]  b_rdata;
  logic [0:0]  b_cs;
  sqi_mode_t   b_mode;
  logic [3:0]  b_data;

  idli_sqi_ctrl_m #(.NUM_CS(3)) u_dut_a (
    .i_sqi_gck(clk), .i_sqi_rst(rst),
    .i_sqi_req_vld(vld && !sel), .o_sqi_req_acp(a_acp),
    .i_sqi_req_wr(wr), .i_sqi_req_cs(cs), .i_sqi_req_addr(addr[15:0]),
    .i_sqi_req_wdata(wdata[15:0]),
    .o_sqi_rsp_vld(a_rsp_vld), .i_sqi_rsp_acp(rsp_acp),
    .o_sqi_rsp_rdata(a_rdata), .o_sqi_rsp_err(a_err),
    .o_sqi_sck(a_sck), .o_sqi_cs(a_cs), .o_sqi_mode(a_mode),
    .i_sqi_data(sio_in), .o_sqi_data(a_data)
  );

  idli_sqi_ctrl_m #(.ADDR_W(24), .DATA_NIBBLES(2), .NUM_CS(1), .DUMMY_CYC(0)) u_dut_b (
    .i_sqi_gck(clk), .i_sqi_rst(rst),
    .i_sqi_req_vld(vld && sel), .o_sqi_req_acp(b_acp),
    .i_sqi_req_wr(wr), .i_sqi_req_cs(cs[0:0]), .i_sqi_req_addr(addr[23:0]),
    .i_sqi_req_wdata(wdata[7:0]),
    .o_sqi_rsp_vld(b_rsp_vld), .i_sqi_rsp_acp(rsp_acp),
    .o_sqi_rsp_rdata(b_rdata), .o_sqi_rsp_err(b_err),
    .o_sqi_sck(b_sck), .o_sqi_cs(b_cs), .o_sqi_mode(b_mode),
    .i_sqi_data(sio_in), .o_sqi_data(b_data)
  );

  logic        m_acp, m_rsp_vld, m_err, m_sck, m_out;
  logic [31:0] m_rdata;
  logic [3:0]  m_cs, m_data;
  assign m_acp     = sel ? b_acp     : a_acp;
  assign m_rsp_vld = sel ? b_rsp_vld : a_rsp_vld;
  assign m_err     = sel ? b_err     : a_err;
  assign m_sck     = sel ? b_sck     : a_sck;
  assign m_out     = sel ? (b_mode == SQI_MODE_OUT) : (a_mode == SQI_MODE_OUT);
  assign m_rdata   = sel ? {24'h0, b_rdata} : {16'h0, a_rdata};
  assign m_cs      = sel ? {3'b111, b_cs}   : {1'b1, a_cs};
  assign m_data    = sel ? b_data : a_data;

  // Configuration of the selected DUT, as seen by the model.
  int aw_n = 4, dmy = 2, dn = 4, ncs = 3;
  int last_lat = 0;

  // Shortest run of all-high chip selects between two transfers.
  logic gap_en = 1'b0;
  logic seen_low;
  int   hi_run, min_gap;
  always @(negedge clk) begin
    if (!gap_en) begin
      seen_low <= 1'b0;
      hi_run   <= 0;
      min_gap  <= 999;
    end else if (m_cs !== 4'hF) begin
      if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap <= hi_run;
      seen_low <= 1'b1;
      hi_run   <= 0;
    end else begin
      hi_run <= hi_run + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic use_dut(input logic s);
    sel = s;
    if (!s) begin aw_n = 4; dmy = 2; dn = 4; ncs = 3; end
    else    begin aw_n = 6; dmy = 0; dn = 2; ncs = 1; end
  endtask

  // Expected {mode_out, nibble} seen on SIO in each slot of a transfer.
  logic [4:0] exp_q[$], obs_q[$];
  task automatic build_exp(input logic w, input logic [31:0] a, input logic [31:0] wd);
    logic [7:0] op;
    op = w ? 8'h02 : 8'h03;
    exp_q.delete();
    exp_q.push_back({1'b1, op[7:4]});
    exp_q.push_back({1'b1, op[3:0]});
    for (int i = aw_n - 1; i >= 0; i--) exp_q.push_back({1'b1, 4'(a >> (4 * i))});
    if (!w) for (int i = 0; i < dmy; i++) exp_q.push_back(5'h00);
    for (int i = dn - 1; i >= 0; i--) exp_q.push_back(w ? {1'b1, 4'(wd >> (4 * i))} : 5'h00);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cs"}, m_cs, 4'hF);
    check({tag, " sck"}, m_sck, 1'b0);
    check({tag, " mode"}, m_out, 1'b0);
    check({tag, " sio"}, m_data, 4'h0);
    check({tag, " rsp_vld"}, m_rsp_vld, 1'b0);
    check({tag, " err"}, m_err, 1'b0);
    check({tag, " rdata"}, m_rdata, 32'h0);
    check({tag, " acp"}, m_acp, 1'b0);
  endtask

  // hold < 0: rsp_acp is already tied high by the caller.
  task automatic run_txn(input string tag, input logic w, input logic [1:0] c,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] dev, input int hold);
    logic        err_exp, cs_bad, sck_bad, stab_bad, hold_bad;
    logic [31:0] rd_exp, mask;
    logic [3:0]  cs_exp, prev_data;
    int          lat_exp, lat, slot, dstart, n;
    err_exp  = (int'(c) >= ncs);
    mask     = 32'((64'd1 << (4 * dn)) - 64'd1);
    build_exp(w, a, wd);
    if (err_exp) exp_q.delete();
    lat_exp  = err_exp ? 1 : 2 * exp_q.size() + 2;
    rd_exp   = (err_exp || w) ? 32'h0 : (dev & mask);
    cs_exp   = err_exp ? 4'hF : ~(4'b0001 << c);
    dstart   = 2 + aw_n + dmy;
    cs_bad   = 1'b0; sck_bad = 1'b0; stab_bad = 1'b0; hold_bad = 1'b0;
    prev_data = 4'h0;
    obs_q.delete();
    if (hold >= 0) rsp_acp = 1'b0;

    n = 0;
    while (m_acp !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check({tag, " req_acp"}, m_acp, 1'b1);
    vld = 1'b1; wr = w; cs = c; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    vld = 1'b0; wr = 1'($urandom); cs = 2'($urandom); addr = $urandom; wdata = $urandom;

    lat = 0; slot = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (m_rsp_vld) begin lat = k; break; end
      if (k <= lat_exp - 2) begin
        if (m_cs !== cs_exp) cs_bad = 1'b1;
      end else if (m_cs !== 4'hF) cs_bad = 1'b1;
      if (m_cs === 4'hF && m_sck) sck_bad = 1'b1;
      if (m_sck) begin
        obs_q.push_back({m_out, m_data});
        if (m_data !== prev_data) stab_bad = 1'b1;
      end else begin
        prev_data = m_data;
        if (m_cs !== 4'hF) begin
          sio_in = (!w && slot >= dstart && slot < dstart + dn) ?
                   4'(dev >> (4 * (dn - 1 - (slot - dstart)))) : 4'($urandom);
          slot++;
        end
      end
    end
    last_lat = lat;

    check({tag, " latency"}, lat, lat_exp);
    check({tag, " cs"}, cs_bad, 1'b0);
    check({tag, " sck idle"}, sck_bad, 1'b0);
    check({tag, " sio stable"}, stab_bad, 1'b0);
    check({tag, " slots"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s slot%0d", tag, i), obs_q[i], exp_q[i]);
    check({tag, " rdata"}, m_rdata, rd_exp);
    check({tag, " err"}, m_err, err_exp);

    if (hold >= 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (m_rsp_vld !== 1'b1 || m_rdata !== rd_exp || m_err !== err_exp || m_acp !== 1'b0)
          hold_bad = 1'b1;
      end
      check({tag, " rsp hold"}, hold_bad, 1'b0);
      @(negedge clk);
      rsp_acp = 1'b1;
      @(posedge clk);
      #1;
      rsp_acp = 1'b0;
      check({tag, " rsp done"}, m_rsp_vld, 1'b0);
      check({tag, " idle acp"}, m_acp, 1'b1);
    end else begin
      @(posedge clk);
      #1;
      check({tag, " rsp done"}, m_rsp_vld, 1'b0);
    end
  endtask

  initial begin
    logic [1:0]  rc;
    logic        rw;
    logic [31:0] ra, rwd, rdev;

    repeat (2) @(posedge clk);
    #1;
    use_dut(1'b0); check_reset_outputs("rstA");
    use_dut(1'b1); check_reset_outputs("rstB");
    use_dut(1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("acp after release A", m_acp, 1'b1);
    use_dut(1'b1);
    check("acp after release B", m_acp, 1'b1);
    use_dut(1'b0);

    run_txn("rd1234", 1'b0, 2'd1, 32'h1234, 32'h0, 32'hABCD, 2);
    check("rd1234 26 cycles", last_lat, 26);
    run_txn("wr00f0", 1'b1, 2'd0, 32'h00F0, 32'h5A5A, 32'h0, 0);
    check("wr00f0 22 cycles", last_lat, 22);
    run_txn("badcs", 1'b0, 2'd3, 32'h4321, 32'h0, 32'h0, 5);

    for (int t = 0; t < 12; t++) begin
      rw = 1'($urandom); rc = 2'($urandom_range(0, 3));
      ra = $urandom & 32'hFFFF; rwd = $urandom & 32'hFFFF; rdev = $urandom & 32'hFFFF;
      run_txn($sformatf("randA%0d", t), rw, rc, ra, rwd, rdev, $urandom_range(0, 5));
    end

    // Reset while the second address nibble is on the bus.
    n_reset_test();

    rsp_acp = 1'b1;
    gap_en  = 1'b1;
    run_txn("b2b0", 1'b0, 2'd2, 32'hBEEF, 32'h0, 32'h1357, -1);
    run_txn("b2b1", 1'b0, 2'd2, 32'h0042, 32'h0, 32'h2468, -1);
    repeat (2) @(negedge clk);
    check("b2b cs gap ok", (min_gap >= 2 && min_gap < 999), 1'b1);
    gap_en  = 1'b0;
    rsp_acp = 1'b0;

    use_dut(1'b1);
    run_txn("rdB", 1'b0, 2'd0, 32'hA1B2C3, 32'h0, 32'h5C, 1);
    check("rdB 22 cycles", last_lat, 22);
    for (int t = 0; t < 6; t++) begin
      rw = 1'($urandom); rc = 2'($urandom_range(0, 1));
      ra = $urandom & 32'hFFFFFF; rwd = $urandom & 32'hFF; rdev = $urandom & 32'hFF;
      run_txn($sformatf("randB%0d", t), rw, rc, ra, rwd, rdev, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic n_reset_test();
    int n;
    use_dut(1'b0);
    n = 0;
    while (m_acp !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    vld = 1'b1; wr = 1'b0; cs = 2'd0; addr = 32'h9876;
    @(posedge clk);
    #1;
    vld = 1'b0;
    repeat (7) @(negedge clk);
    check("mid cs low", m_cs, 4'b1110);
    check("mid addr nibble", {m_out, m_data}, 5'h18);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    check("midrst acp held", m_acp, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst acp back", m_acp, 1'b1);
    run_txn("afterrst", 1'b0, 2'd2, 32'h0F1E, 32'h0, 32'hC0DE, 1);
  endtask

endmodule
